ipg_rx_extractor: RTL and testbench

IPG_RX_EXTRACTOR -- requirements
Module: ipg_rx_extractor

---
 rtl/ipg_rx_extractor_pkg.sv | 13 +
 rtl/ipg_rx_extractor_mask.sv | 17 +
 rtl/ipg_rx_extractor.sv | 71 +++++++
 tb/tb_ipg_rx_extractor.sv | 99 +++++++++
 4 files changed

// File: rtl/ipg_rx_extractor_pkg.sv
// Shared constants for the RX IPG extractor.
// Block framing fields of 64b/66b control blocks.
package ipg_rx_extractor_pkg;

    localparam logic [1:0]  SYNC_DATA       = 2'b01;
    localparam logic [1:0]  SYNC_CTRL       = 2'b10;
    localparam logic [7:0]  BLOCK_TYPE_CTRL = 8'h1E;
    localparam int          IPG_LEN_LSB     = 8;
    localparam int          IPG_LEN_W       = 6;
    localparam int          IPG_DATA_LSB    = 16;
    localparam logic [63:0] IDLE_BLOCK      = 64'h1E;

endpackage

// File: rtl/ipg_rx_extractor_mask.sv
// L-bit right-justified mask generator.
// Produces ones in bits [len-1:0], all zero for len==0.
module ipg_len_mask
    import ipg_rx_extractor_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [IPG_LEN_W-1:0]  i_len,
    output logic [DATA_WIDTH-1:0] o_mask
);

    logic [DATA_WIDTH-1:0] w_one;

    assign w_one  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    assign o_mask = (w_one << i_len) - w_one;

endmodule

// File: rtl/ipg_rx_extractor.sv
// Strips IPG payload carried in all-idle control blocks on the RX path.
// Recovered stream sees plain idles; payload leaves on a side channel.
module ipg_rx_extractor
    import ipg_rx_extractor_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int IPG_MAX_LEN = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] encoded_rx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
    output logic [DATA_WIDTH-1:0] recoved_encoded_rx_data,
    output logic [HDR_WIDTH-1:0]  recoved_encoded_rx_hdr,
    output logic [DATA_WIDTH-1:0] rx_ipg_data,
    output logic [IPG_LEN_W-1:0]  rx_len
);

    logic                  w_is_ctrl;
    logic                  w_is_ipg;
    logic [IPG_LEN_W-1:0]  w_len;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_payload;

    logic [DATA_WIDTH-1:0] r_data;
    logic [HDR_WIDTH-1:0]  r_hdr;
    logic [DATA_WIDTH-1:0] r_ipg;
    logic [IPG_LEN_W-1:0]  r_len;

    assign w_len     = encoded_rx_data[IPG_LEN_LSB +: IPG_LEN_W];
    assign w_is_ctrl = (encoded_rx_hdr == SYNC_CTRL) &&
                       (encoded_rx_data[7:0] == BLOCK_TYPE_CTRL);
    // Oversized lengths are left in place so the decoder flags them.
    assign w_is_ipg  = w_is_ctrl && (w_len != '0) &&
                       ({26'd0, w_len} <= 32'(IPG_MAX_LEN));

    ipg_len_mask #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mask (
        .i_len  (w_len),
        .o_mask (w_mask)
    );

    assign w_payload = (encoded_rx_data >> IPG_DATA_LSB) & w_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr  <= SYNC_CTRL;
            r_data <= IDLE_BLOCK;
            r_ipg  <= '0;
            r_len  <= '0;
        end else if (w_is_ipg) begin
            r_hdr  <= SYNC_CTRL;
            r_data <= IDLE_BLOCK;
            r_ipg  <= w_payload;
            r_len  <= w_len;
        end else begin
            r_hdr  <= encoded_rx_hdr;
            r_data <= encoded_rx_data;
            r_ipg  <= '0;
            r_len  <= '0;
        end
    end

    assign recoved_encoded_rx_data = r_data;
    assign recoved_encoded_rx_hdr  = r_hdr;
    assign rx_ipg_data             = r_ipg;
    assign rx_len                  = r_len;

endmodule

// File: tb/tb_ipg_rx_extractor.sv
// Directed bench for ipg_rx_extractor.
// One block per cycle, outputs checked 1 ns after the following edge.
module tb_ipg_rx_extractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = 64'd0;
    logic [1:0]  in_hdr = 2'b00;
    logic [63:0] out_data;
    logic [1:0]  out_hdr;
    logic [63:0] ipg_data;
    logic [5:0]  len;

    int n_vec = 0;
    int n_err = 0;

    ipg_rx_extractor dut (
        .clk                     (clk),
        .rst                     (rst),
        .encoded_rx_data         (in_data),
        .encoded_rx_hdr          (in_hdr),
        .recoved_encoded_rx_data (out_data),
        .recoved_encoded_rx_hdr  (out_hdr),
        .rx_ipg_data             (ipg_data),
        .rx_len                  (len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input string tag, input logic r,
                         input logic [1:0] h, input logic [63:0] d,
                         input logic [1:0] eh, input logic [63:0] ed,
                         input logic [63:0] ei, input logic [5:0] el);
        @(negedge clk);
        rst     = r;
        in_hdr  = h;
        in_data = d;
        @(posedge clk);
        #1;
        chk({tag, ".hdr"},  {62'd0, out_hdr}, {62'd0, eh});
        chk({tag, ".data"}, out_data, ed);
        chk({tag, ".ipg"},  ipg_data, ei);
        chk({tag, ".len"},  {58'd0, len}, {58'd0, el});
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        apply("reset", 1'b1, 2'b01, 64'h0123_4567_89AB_CDEF,
              2'b10, 64'h1E, 64'd0, 6'd0);

        apply("ipg32", 1'b0, 2'b10, 64'hFFFF_DEAD_BEEF_201E,
              2'b10, 64'h1E, 64'hDEAD_BEEF, 6'd32);
        apply("ipg48", 1'b0, 2'b10, 64'hCAFE_1234_5678_301E,
              2'b10, 64'h1E, 64'h0000_CAFE_1234_5678, 6'd48);
        apply("ipg1", 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_011E,
              2'b10, 64'h1E, 64'h1, 6'd1);
        apply("len63", 1'b0, 2'b10, 64'h0000_0000_0000_3F1E,
              2'b10, 64'h0000_0000_0000_3F1E, 64'd0, 6'd0);
        apply("len49", 1'b0, 2'b10, 64'h1111_2222_3333_311E,
              2'b10, 64'h1111_2222_3333_311E, 64'd0, 6'd0);
        apply("len0", 1'b0, 2'b10, 64'h1234_0000_0001_C01E,
              2'b10, 64'h1234_0000_0001_C01E, 64'd0, 6'd0);
        apply("idle", 1'b0, 2'b10, 64'h1E,
              2'b10, 64'h1E, 64'd0, 6'd0);
        apply("data", 1'b0, 2'b01, 64'h0123_4567_89AB_CDEF,
              2'b01, 64'h0123_4567_89AB_CDEF, 64'd0, 6'd0);
        apply("start", 1'b0, 2'b10, 64'hD555_5555_5555_5578,
              2'b10, 64'hD555_5555_5555_5578, 64'd0, 6'd0);
        apply("data1e", 1'b0, 2'b01, 64'h0000_0000_0000_201E,
              2'b01, 64'h0000_0000_0000_201E, 64'd0, 6'd0);
        apply("hdr11", 1'b0, 2'b11, 64'h0000_0000_ABCD_101E,
              2'b11, 64'h0000_0000_ABCD_101E, 64'd0, 6'd0);
        apply("hdr00", 1'b0, 2'b00, 64'h0000_0000_ABCD_101E,
              2'b00, 64'h0000_0000_ABCD_101E, 64'd0, 6'd0);

        apply("pre_rst", 1'b0, 2'b10, 64'h0000_0000_00A5_081E,
              2'b10, 64'h1E, 64'hA5, 6'd8);
        apply("mid_rst", 1'b1, 2'b10, 64'h0000_0000_ABCD_101E,
              2'b10, 64'h1E, 64'd0, 6'd0);
        apply("post_rst", 1'b0, 2'b10, 64'h0000_0000_ABCD_101E,
              2'b10, 64'h1E, 64'hABCD, 6'd16);
        apply("post_rst2", 1'b0, 2'b01, 64'hFEDC_BA98_7654_3210,
              2'b01, 64'hFEDC_BA98_7654_3210, 64'd0, 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
